// File: rtl/uart_frame_rx.sv
// uart_frame_rx: assembles SOF/LEN/payload/CRC-8 frames from a UART byte stream and
// holds one verified frame for the consumer behind a valid/ack handshake.
//
// state   | meaning
// HUNT    | waiting for SOF; also parks here while a frame is held
// LEN     | expecting the length byte
// PAYLOAD | storing payload bytes
// CHECK   | expecting the CRC byte
// DONE    | publish the frame (1 cycle)
// ERR     | report a discarded frame (1 cycle)
module uart_frame_rx #(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       frame_valid,
    output logic [7:0] frame_len,
    input  logic       frame_ack,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       crc_error,
    output logic       overrun,
    output logic [1:0] status
);

    localparam int             AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
    localparam logic [7:0]     MAX_LEN_B  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t        state, state_next;
    logic [7:0]    crc;
    logic [7:0]    len_q;
    logic [7:0]    idx;
    logic [TW-1:0] timer;
    logic [7:0]    buffer [MAX_LEN];

    logic byte_ok, active, timed_out, len_bad;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // a held frame blocks all input; bytes are counted as overruns instead
    assign byte_ok   = rx_done & ~frame_valid;
    assign active    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
    assign timed_out = active && !rx_done && (timer == TIMER_LAST);
    assign len_bad   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);

    always_comb begin
        state_next = state;
        case (state)
            S_HUNT: begin
                if (byte_ok && rx_data == SOF_BYTE) state_next = S_LEN;
            end
            S_LEN: begin
                if (byte_ok)        state_next = len_bad ? S_ERR : S_PAYLOAD;
                else if (timed_out) state_next = S_ERR;
            end
            S_PAYLOAD: begin
                if (byte_ok) begin
                    if (idx == len_q - 8'd1) state_next = S_CHECK;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_CHECK: begin
                if (byte_ok)        state_next = (rx_data == crc) ? S_DONE : S_ERR;
                else if (timed_out) state_next = S_ERR;
            end
            S_DONE:  state_next = S_HUNT;
            S_ERR:   state_next = S_HUNT;
            default: state_next = S_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_HUNT;
            crc         <= 8'd0;
            len_q       <= 8'd0;
            idx         <= 8'd0;
            timer       <= '0;
            frame_valid <= 1'b0;
            frame_len   <= 8'd0;
            rd_data     <= 8'd0;
            crc_error   <= 1'b0;
            overrun     <= 1'b0;
            status      <= 2'b00;
        end else begin
            state     <= state_next;
            crc_error <= (state_next == S_ERR);
            overrun   <= rx_done & frame_valid;
            timer     <= (!active || byte_ok) ? '0 : timer + TIMER_ONE;

            case (state)
                S_HUNT: if (byte_ok && rx_data == SOF_BYTE) crc <= 8'd0;
                S_LEN: begin
                    if (byte_ok && !len_bad) begin
                        len_q <= rx_data;
                        crc   <= crc8_next(crc, rx_data);
                        idx   <= 8'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (byte_ok) begin
                        crc <= crc8_next(crc, rx_data);
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase

            if (state == S_HUNT && state_next == S_LEN) status <= 2'b01;
            else if (state == S_DONE)                   status <= 2'b10;
            else if (state_next == S_ERR)               status <= 2'b11;

            if (state == S_DONE) begin
                frame_valid <= 1'b1;
                frame_len   <= len_q;
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end

            rd_data <= (rd_addr < MAX_LEN_B) ? buffer[rd_addr[AW-1:0]] : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && byte_ok) buffer[idx[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus pushes expected frame outcomes, a monitor
// acting as the frame consumer pops and compares them when the DUT reports a frame or error.
module tb_uart_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 100;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset, rx_done, frame_ack;
    logic [7:0] rx_data, rd_addr;
    logic       frame_valid, crc_error, overrun;
    logic [7:0] frame_len, rd_data;
    logic [1:0] status;

    uart_frame_rx #(.MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .crc_error(crc_error),
        .overrun(overrun), .status(status)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int last_byte_cyc = 0, err_cyc = 0, ovr_cnt = 0;
    bit auto_ack = 1'b1;

    bit         exp_err_q[$];
    int         exp_len_q[$];
    logic [7:0] exp_data_q[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (overrun) ovr_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // CRC-8 (poly x^8+x^2+x+1) as polynomial long division of the message shifted by 8 bits
    function automatic logic [7:0] crc_ref(input bq_t msg);
        bit         bits[$];
        logic [7:0] rem;
        bit         top;
        rem = 8'd0;
        foreach (msg[k]) for (int i = 7; i >= 0; i--) bits.push_back(msg[k][i]);
        for (int i = 0; i < 8; i++) bits.push_back(1'b0);
        foreach (bits[k]) begin
            top = rem[7];
            rem = {rem[6:0], bits[k]};
            if (top) rem = rem ^ 8'h07;
        end
        return rem;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        last_byte_cyc = cyc;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] len, input bq_t payload,
                              input logic [7:0] crc_byte, input int maxgap);
        bq_t msg;
        bit  good;
        if (len == 0 || len > MAX_LEN) begin
            exp_err_q.push_back(1'b1);
            exp_len_q.push_back(0);
            send_byte(8'hA5, $urandom_range(0, maxgap));
            send_byte(len, $urandom_range(0, maxgap));
            return;
        end
        msg.push_back(len);
        foreach (payload[i]) msg.push_back(payload[i]);
        good = (crc_ref(msg) == crc_byte);
        exp_err_q.push_back(!good);
        exp_len_q.push_back(int'(len));
        if (good) foreach (payload[i]) exp_data_q.push_back(payload[i]);
        send_byte(8'hA5, $urandom_range(0, maxgap));
        foreach (msg[i]) send_byte(msg[i], $urandom_range(0, maxgap));
        send_byte(crc_byte, $urandom_range(0, maxgap));
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((exp_err_q.size() != 0 || frame_valid) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk({"idle_reached_", name}, 32'(t < 3000), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_frame_len"},   32'(frame_len),   32'd0);
        chk({tag, "_rd_data"},     32'(rd_data),     32'd0);
        chk({tag, "_crc_error"},   32'(crc_error),   32'd0);
        chk({tag, "_overrun"},     32'(overrun),     32'd0);
        chk({tag, "_status"},      32'(status),      32'd0);
    endtask

    // monitor / consumer
    initial begin
        bit         fv_prev = 1'b0;
        bit         e;
        int         l;
        logic [7:0] ebuf [256];
        rd_addr   = 8'd0;
        frame_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                fv_prev = frame_valid;
                continue;
            end
            if (crc_error) begin
                err_cyc = cyc;
                if (exp_err_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_crc_error: crc_error=1 with no frame pending, required 0");
                end else begin
                    e = exp_err_q.pop_front();
                    l = exp_len_q.pop_front();
                    chk("outcome_is_error", 32'd1, 32'(e));
                    chk("status_after_error", 32'(status), 32'd3);
                end
            end
            if (frame_valid && !fv_prev) begin
                if (exp_err_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_frame: frame_valid rose with no frame pending, required no frame");
                end else begin
                    e = exp_err_q.pop_front();
                    l = exp_len_q.pop_front();
                    chk("outcome_is_error", 32'd0, 32'(e));
                    if (!e) begin
                        chk("frame_len", 32'(frame_len), 32'(l));
                        chk("status_after_ok", 32'(status), 32'd2);
                        for (int i = 0; i < l; i++) begin
                            ebuf[i] = exp_data_q.pop_front();
                            rd_addr = 8'(i);
                            @(negedge clk);
                            chk("rd_data", 32'(rd_data), 32'(ebuf[i]));
                        end
                        rd_addr = 8'($urandom_range(MAX_LEN, 255));
                        @(negedge clk);
                        chk("rd_data_out_of_range", 32'(rd_data), 32'd0);
                        if (!auto_ack) begin
                            while (!auto_ack) @(negedge clk);
                            chk("frame_len_stable", 32'(frame_len), 32'(l));
                            for (int i = 0; i < l; i++) begin
                                rd_addr = 8'(i);
                                @(negedge clk);
                                chk("rd_data_stable", 32'(rd_data), 32'(ebuf[i]));
                            end
                        end
                    end
                    chk("frame_valid_held", 32'(frame_valid), 32'd1);
                    frame_ack = 1'b1;
                    @(negedge clk);
                    frame_ack = 1'b0;
                    chk("frame_valid_after_ack", 32'(frame_valid), 32'd0);
                end
            end
            fv_prev = frame_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        bq_t        p;
        logic [7:0] len, crc_b, g;
        int         r, t, o0;

        reset = 1'b1; rx_done = 1'b0; rx_data = 8'd0;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        send_byte(8'h3C, 1); send_byte(8'h5A, 1);
        p = {8'h00};             send_frame(8'd1, p, 8'h15, 1); wait_idle("len1");
        p = {8'h01, 8'h02};      send_frame(8'd2, p, 8'hCD, 1); wait_idle("len2");
        p = {8'h00};             send_frame(8'd1, p, 8'h16, 1); wait_idle("badcrc");
        p = {8'h00};             send_frame(8'd1, p, 8'h15, 0); wait_idle("after_badcrc");
        send_byte(8'h3C, 0); send_byte(8'h5A, 0);
        p = {};                  send_frame(8'd0,  p, 8'h00, 1); wait_idle("len0");
        p = {};                  send_frame(8'h11, p, 8'h00, 1); wait_idle("len17");

        exp_err_q.push_back(1'b1); exp_len_q.push_back(0);
        send_byte(8'hA5, 0); send_byte(8'h02, 2); send_byte(8'h01, 0);
        wait_idle("timeout");
        chk("timeout_latency", 32'(err_cyc - last_byte_cyc), 32'(TIMEOUT));
        p = {8'h5A, 8'hA5, 8'h3C};
        len = 8'd3;
        p.push_front(len); crc_b = crc_ref(p); void'(p.pop_front());
        send_frame(len, p, crc_b, 2); wait_idle("after_timeout");

        auto_ack = 1'b0;
        p = {8'h11, 8'h22, 8'h33};
        p.push_front(8'd3); crc_b = crc_ref(p); void'(p.pop_front());
        send_frame(8'd3, p, crc_b, 1);
        t = 0;
        while (!frame_valid && t < 200) begin @(posedge clk); #1; t++; end
        chk("held_frame_valid", 32'(frame_valid), 32'd1);
        o0 = ovr_cnt;
        send_byte(8'hA5, 1); send_byte(8'h01, 0); send_byte(8'h00, 2); send_byte(8'h15, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("overrun_count", 32'(ovr_cnt - o0), 32'd4);
        chk("status_while_held", 32'(status), 32'd2);
        auto_ack = 1'b1;
        wait_idle("overrun");

        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h3C;
                send_byte(g, $urandom_range(0, 2));
            end
            p = {};
            r = $urandom_range(0, 9);
            if (r == 0)      len = 8'd0;
            else if (r == 1) len = 8'($urandom_range(MAX_LEN + 1, 255));
            else             len = 8'($urandom_range(1, MAX_LEN));
            if (len != 0 && len <= MAX_LEN) begin
                for (int i = 0; i < int'(len); i++) p.push_back(8'($urandom));
                p.push_front(len); crc_b = crc_ref(p); void'(p.pop_front());
                if ($urandom_range(0, 3) == 0) crc_b = crc_b ^ 8'($urandom_range(1, 255));
            end else begin
                crc_b = 8'd0;
            end
            send_frame(len, p, crc_b, 2);
            wait_idle("random");
        end

        send_byte(8'hA5, 0); send_byte(8'h05, 1); send_byte(8'h11, 0); send_byte(8'h22, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("mid_frame_reset");
        reset = 1'b0;
        repeat (TIMEOUT + 50) begin @(posedge clk); #1; end
        chk("status_after_reset_idle", 32'(status), 32'd0);
        chk("frame_valid_after_reset_idle", 32'(frame_valid), 32'd0);
        p = {8'hC3, 8'h7E};
        p.push_front(8'd2); crc_b = crc_ref(p); void'(p.pop_front());
        send_frame(8'd2, p, crc_b, 1); wait_idle("after_reset");

        chk("scoreboard_empty", 32'(exp_err_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
